// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_pkg;

  localparam int unsigned PACKAGE_SIZE_DEFAULT = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StXfer,
    StRdwait,
    StDone
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    idx
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    gnt   = '0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IdxW + 1)'(k);
      if (sum >= (IdxW + 1)'(NUM_REQ)) begin
        sum = sum - (IdxW + 1)'(NUM_REQ);
      end
      cand = sum[IdxW-1:0];
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sequencer sharing one SPI driver between NUM_REQ requesters.
// Optional per-transaction watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned PACKAGE_SIZE   = PACKAGE_SIZE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_rw,
  input  logic [NUM_REQ*(PACKAGE_SIZE-1)-1:0] req_addr,
  input  logic [NUM_REQ*PACKAGE_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                ack,
  output logic [PACKAGE_SIZE-1:0]           rdata,
  output logic                              err,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              spi_send,
  output logic                              spi_rw,
  output logic [PACKAGE_SIZE-2:0]           spi_addr,
  output logic [PACKAGE_SIZE-1:0]           spi_wdata,
  input  logic                              spi_busy,
  input  logic                              spi_data_ready,
  input  logic [PACKAGE_SIZE-1:0]           spi_rdata
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned AddrW = PACKAGE_SIZE - 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("spi_txn_arbiter: parameter out of range");
  end

  arb_state_e state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d, idx_q, idx_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d, ack_q, ack_d;
  logic [PACKAGE_SIZE-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [AddrW-1:0]        addr_q, addr_d;
  logic                    send_q, send_d, rw_q, rw_d;

  logic                    pick_valid;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IdxW-1:0]         pick_idx;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active, timeout, err_q, err_d;

  assign active  = state_q inside {StIssue, StXfer, StRdwait};
  assign timeout = active && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign cnt_d   = active ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    send_d  = send_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        // A driver frame can still be in flight after a reset; never overlap it.
        if (!spi_busy && pick_valid) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          rw_d    = req_rw[pick_idx];
          addr_d  = req_addr[pick_idx*AddrW +: AddrW];
          wdata_d = req_wdata[pick_idx*PACKAGE_SIZE +: PACKAGE_SIZE];
          send_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (spi_busy) begin
          send_d  = 1'b0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (!spi_busy) begin
          state_d = (rw_q == RW_READ) ? StRdwait : StDone;
        end
      end
      StRdwait: begin
        if (spi_data_ready) begin
          rdata_d = spi_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef SPI_ARB_TIMEOUT_EN
    if (timeout) begin
      send_d  = 1'b0;
      rdata_d = '0;
      err_d   = 1'b1;
      state_d = StDone;
    end
`endif

    if (state_d == StDone && state_q != StDone) begin
      ack_d = gnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      send_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      send_q  <= send_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign grant     = gnt_q;
  assign spi_send  = send_q;
  assign spi_rw    = rw_q;
  assign spi_addr  = addr_q;
  assign spi_wdata = wdata_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter with a behavioural SPI driver model.
module tb_spi_txn_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned P  = 8;
  localparam int unsigned AW = P - 1;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req, req_rw;
  logic [N*AW-1:0] req_addr;
  logic [N*P-1:0]  req_wdata;
  logic [N-1:0]    ack, grant;
  logic [P-1:0]    rdata, spi_wdata, spi_rdata;
  logic            err, spi_send, spi_rw, spi_busy, spi_data_ready;
  logic [AW-1:0]   spi_addr;

  always #5 clk = ~clk;

  spi_txn_arbiter #(
    .NUM_REQ       (N),
    .PACKAGE_SIZE  (P),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .ack           (ack),
    .rdata         (rdata),
    .err           (err),
    .grant         (grant),
    .spi_send      (spi_send),
    .spi_rw        (spi_rw),
    .spi_addr      (spi_addr),
    .spi_wdata     (spi_wdata),
    .spi_busy      (spi_busy),
    .spi_data_ready(spi_data_ready),
    .spi_rdata     (spi_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Peripheral contents seen by the driver model.
  function automatic logic [P-1:0] mem_rd(input logic [AW-1:0] a);
    return {1'b0, a} ^ 8'h43;
  endfunction

  // ---------------- SPI driver model ----------------
  bit            drv_en     = 1'b1;
  int            fixed_busy = 0;
  int            n_frames   = 0;
  logic          f_rw;
  logic [AW-1:0] f_addr;
  logic [P-1:0]  f_wdata;

  initial begin : driver
    spi_busy       = 1'b0;
    spi_data_ready = 1'b0;
    spi_rdata      = '0;
    forever begin
      @(negedge clk);
      if (drv_en && spi_send && !spi_busy) begin
        int bl;
        f_rw    = spi_rw;
        f_addr  = spi_addr;
        f_wdata = spi_wdata;
        n_frames++;
        spi_data_ready = 1'b0;
        spi_busy       = 1'b1;
        bl = (fixed_busy > 0) ? fixed_busy : int'($urandom_range(1, 5));
        repeat (bl) @(negedge clk);
        spi_busy = 1'b0;
        if (f_rw) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          spi_rdata      = mem_rd(f_addr);
          spi_data_ready = 1'b1;
        end
      end
    end
  end

  // ---------------- cycle invariants ----------------
  logic prev_send = 1'b0;
  logic [N-1:0] prev_ack = '0;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      check("send_rise_while_busy", 32'(spi_send && !prev_send && spi_busy), 32'd0);
      check("ack_single_cycle", 32'(|(ack & prev_ack)), 32'd0);
      prev_send = spi_send;
      prev_ack  = ack;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- helpers ----------------
  task automatic set_req(input int i, input bit on, input bit rw, input logic [AW-1:0] a,
                         input logic [P-1:0] d);
    req[i]              = on;
    req_rw[i]           = rw;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*P +: P]  = d;
  endtask

  task automatic wait_ack(output logic [N-1:0] a, input int limit);
    a = '0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (ack !== '0) begin
        a = ack;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL ack_wait: got no ack, expected one within %0d cycles", limit);
  endtask

  task automatic wait_busy(input logic level, input int limit);
    for (int c = 0; c < limit; c++) begin
      if (spi_busy === level) return;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL busy_wait: got busy=%0b, expected %0b within %0d cycles", spi_busy, level, limit);
  endtask

  // ---------------- reference model for random traffic ----------------
  bit            m_req[N];
  bit            m_rw[N];
  logic [AW-1:0] m_addr[N];
  logic [P-1:0]  m_wd[N];
  int            m_ptr;
  logic [P-1:0]  m_rdata;

  function automatic int predict();
    for (int k = 0; k < N; k++) begin
      if (m_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic new_fields(input int i);
    m_rw[i]   = 1'($urandom_range(0, 1));
    m_addr[i] = AW'($urandom);
    m_wd[i]   = P'($urandom);
  endtask

  task automatic apply_model();
    for (int i = 0; i < N; i++) set_req(i, m_req[i], m_rw[i], m_addr[i], m_wd[i]);
  endtask

  typedef struct {
    int            idx;
    bit            rw;
    logic [AW-1:0] addr;
    logic [P-1:0]  wdata;
    logic [P-1:0]  exp_rdata;
  } vec_t;

  vec_t vt[6];

  initial begin : stim
    logic [N-1:0] a;
    int           f0;
    int           exp;

    vt[0] = '{idx: 0, rw: 1'b0, addr: 7'h15, wdata: 8'hA5, exp_rdata: 8'h00};
    vt[1] = '{idx: 2, rw: 1'b1, addr: 7'h7F, wdata: 8'h00, exp_rdata: 8'h3C};
    vt[2] = '{idx: 1, rw: 1'b0, addr: 7'h22, wdata: 8'h5A, exp_rdata: 8'h3C};
    vt[3] = '{idx: 3, rw: 1'b1, addr: 7'h10, wdata: 8'h00, exp_rdata: 8'h53};
    vt[4] = '{idx: 0, rw: 1'b1, addr: 7'h01, wdata: 8'h00, exp_rdata: 8'h42};
    vt[5] = '{idx: 3, rw: 1'b0, addr: 7'h7E, wdata: 8'hFF, exp_rdata: 8'h42};

    rst = 1'b1;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_grant", grant, 0);
    check("rst_err", err, 0);
    check("rst_send", spi_send, 0);
    check("rst_rw", spi_rw, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", spi_addr, 0);
    check("rst_wdata", spi_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Isolated transactions from the table.
    foreach (vt[i]) begin
      f0 = n_frames;
      set_req(vt[i].idx, 1'b1, vt[i].rw, vt[i].addr, vt[i].wdata);
      wait_ack(a, 100);
      check("vec_ack", a, 32'd1 << vt[i].idx);
      check("vec_rdata", rdata, vt[i].exp_rdata);
      check("vec_err", err, 0);
      check("vec_frames", n_frames - f0, 1);
      check("vec_frame_rw", f_rw, vt[i].rw);
      check("vec_frame_addr", f_addr, vt[i].addr);
      if (!vt[i].rw) check("vec_frame_wdata", f_wdata, vt[i].wdata);
      set_req(vt[i].idx, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
    end

    // Contention: all requesters held; service must rotate 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(8'h40 + i), P'(8'h10 * i + 1));
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, 100);
      check("rr_ack", a, 32'd1 << (k % N));
      check("rr_frame_addr", f_addr, 8'h40 + (k % N));
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Fields change mid-transfer; driver inputs must not follow.
    set_req(1, 1'b1, 1'b0, 7'h2A, 8'hC3);
    wait_busy(1'b1, 50);
    set_req(1, 1'b1, 1'b0, 7'h55, 8'h00);
    a = '0;
    for (int c = 0; c < 100 && a == '0; c++) begin
      @(negedge clk);
      check("stable_addr", spi_addr, 7'h2A);
      check("stable_wdata", spi_wdata, 8'hC3);
      a = ack;
    end
    check("stable_ack", a, 4'b0010);
    check("stable_frame_addr", f_addr, 7'h2A);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Reset during a long driver frame.
    fixed_busy = 12;
    set_req(0, 1'b1, 1'b0, 7'h33, 8'h99);
    wait_busy(1'b1, 50);
    f0 = n_frames;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fixed_busy = 0;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_send", spi_send, 0);
    check("mid_rst_ack", ack, 0);
    for (int c = 0; c < 50 && spi_busy; c++) begin
      check("mid_rst_no_ack", ack, 0);
      check("mid_rst_no_send", spi_send, 0);
      @(negedge clk);
    end
    wait_ack(a, 100);
    check("post_rst_ack", a, 4'b0001);
    check("post_rst_frames", n_frames - f0, 1);
    check("post_rst_frame_addr", f_addr, 7'h33);
    check("post_rst_frame_wdata", f_wdata, 8'h99);
    set_req(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Random traffic against the model. Reset cleared rdata, last owner was 0.
    m_ptr   = 1;
    m_rdata = '0;
    for (int i = 0; i < N; i++) begin
      m_req[i] = 1'($urandom_range(0, 1));
      new_fields(i);
    end
    m_req[$urandom_range(0, N - 1)] = 1'b1;
    apply_model();
    for (int t = 0; t < 40; t++) begin
      exp = predict();
      wait_ack(a, 200);
      check("rand_ack", a, 32'd1 << exp);
      check("rand_frame_rw", f_rw, m_rw[exp]);
      check("rand_frame_addr", f_addr, m_addr[exp]);
      if (!m_rw[exp]) check("rand_frame_wdata", f_wdata, m_wd[exp]);
      if (m_rw[exp]) m_rdata = mem_rd(m_addr[exp]);
      check("rand_rdata", rdata, m_rdata);
      check("rand_err", err, 0);
      m_ptr = (exp + 1) % N;
      m_req[exp] = 1'($urandom_range(0, 1));
      new_fields(exp);
      for (int i = 0; i < N; i++) begin
        if (i != exp && !m_req[i] && $urandom_range(0, 2) == 0) begin
          m_req[i] = 1'b1;
          new_fields(i);
        end
      end
      if (predict() < 0) m_req[$urandom_range(0, N - 1)] = 1'b1;
      apply_model();
    end
    req = '0;
    repeat (3) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    // Silent driver: watchdog must complete the transaction with an error.
    drv_en = 1'b0;
    set_req(2, 1'b1, 1'b1, 7'h11, 8'h00);
    wait_ack(a, 40);
    check("to_ack", a, 4'b0100);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    set_req(2, 1'b0, 1'b0, '0, '0);
    drv_en = 1'b1;
    @(negedge clk);
    check("to_send_cleared", spi_send, 0);
    set_req(3, 1'b1, 1'b0, 7'h0C, 8'h77);
    wait_ack(a, 100);
    check("to_next_ack", a, 4'b1000);
    check("to_next_err", err, 0);
    check("to_next_addr", f_addr, 7'h0C);
    set_req(3, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
